// File: rtl/crossbar_nxn_rr_buffered.sv
// NxN buffered crossbar: per-input FIFO carrying {dest, data}, per-output round-robin
// arbiter feeding a registered valid/ready output stage.

module xbar_in_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] push_data,
  input  logic         push,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW:0]             wr_ptr, rd_ptr;
  logic                    push_ok, pop_ok;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

module xbar_out_port #(
  parameter int WIDTH  = 4,
  parameter int DEST_W = 1,
  parameter int PORTS  = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [PORTS-1:0]            req,
  input  logic [PORTS-1:0][WIDTH-1:0] head_data,
  input  logic                        out_ready,
  output logic [PORTS-1:0]            grant,
  output logic [WIDTH-1:0]            out_data,
  output logic [DEST_W-1:0]           out_src,
  output logic                        out_valid
);
  logic [DEST_W-1:0] last_grant, gnt_idx, idx;
  logic              found, load;

  // Search starts one past the last winner; DEST_W-bit add wraps modulo PORTS.
  always_comb begin
    gnt_idx = last_grant;
    idx     = last_grant;
    found   = 1'b0;
    for (int k = 1; k <= PORTS; k++) begin
      idx = last_grant + DEST_W'(k);
      if (!found && req[idx]) begin
        gnt_idx = idx;
        found   = 1'b1;
      end
    end
  end

  assign load = (~out_valid | out_ready) & found;

  always_comb begin
    grant = '0;
    if (load) grant[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data   <= '0;
      out_src    <= '0;
      out_valid  <= 1'b0;
      last_grant <= '1;
    end else if (load) begin
      out_data   <= head_data[gnt_idx];
      out_src    <= gnt_idx;
      out_valid  <= 1'b1;
      last_grant <= gnt_idx;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end
endmodule

module crossbar_nxn_rr_buffered #(
  parameter int WIDTH  = 4,
  parameter int DEST_W = 1,
  parameter int DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [(2**DEST_W)*WIDTH-1:0]  in_data,
  input  logic [(2**DEST_W)*DEST_W-1:0] in_dest,
  input  logic [(2**DEST_W)-1:0]        in_valid,
  output logic [(2**DEST_W)-1:0]        in_ready,
  output logic [(2**DEST_W)*WIDTH-1:0]  out_data,
  output logic [(2**DEST_W)*DEST_W-1:0] out_src,
  output logic [(2**DEST_W)-1:0]        out_valid,
  input  logic [(2**DEST_W)-1:0]        out_ready
);
  localparam int PORTS = 2**DEST_W;

  typedef struct packed {
    logic [DEST_W-1:0] dest;
    logic [WIDTH-1:0]  data;
  } beat_t;

  logic  [PORTS-1:0][WIDTH-1:0]  in_data_a, head_data, out_data_a;
  logic  [PORTS-1:0][DEST_W-1:0] in_dest_a, out_src_a;
  beat_t [PORTS-1:0]             in_beat, head;
  logic  [PORTS-1:0]             empty, full, push, pop;
  logic  [PORTS-1:0][PORTS-1:0]  req, gnt;  // [output][input]

  assign in_data_a = in_data;
  assign in_dest_a = in_dest;
  assign out_data  = out_data_a;
  assign out_src   = out_src_a;

  for (genvar i = 0; i < PORTS; i++) begin : g_in
    assign in_beat[i]   = '{dest: in_dest_a[i], data: in_data_a[i]};
    assign in_ready[i]  = rst_n & ~full[i];
    assign push[i]      = in_valid[i] & in_ready[i];
    assign head_data[i] = head[i].data;

    xbar_in_fifo #(.W($bits(beat_t)), .DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push_data (in_beat[i]),
      .push      (push[i]),
      .pop       (pop[i]),
      .head      (head[i]),
      .empty     (empty[i]),
      .full      (full[i])
    );
  end

  // Each head names exactly one output, so an input wins at most one grant per cycle.
  for (genvar j = 0; j < PORTS; j++) begin : g_req
    for (genvar i = 0; i < PORTS; i++) begin : g_src
      assign req[j][i] = ~empty[i] & (head[i].dest == DEST_W'(j));
    end
  end

  always_comb begin
    pop = '0;
    for (int j = 0; j < PORTS; j++)
      for (int i = 0; i < PORTS; i++)
        pop[i] = pop[i] | gnt[j][i];
  end

  for (genvar j = 0; j < PORTS; j++) begin : g_out
    xbar_out_port #(.WIDTH(WIDTH), .DEST_W(DEST_W), .PORTS(PORTS)) u_out (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req[j]),
      .head_data (head_data),
      .out_ready (out_ready[j]),
      .grant     (gnt[j]),
      .out_data  (out_data_a[j]),
      .out_src   (out_src_a[j]),
      .out_valid (out_valid[j])
    );
  end
endmodule

// File: tb/tb_crossbar_nxn_rr_buffered.sv
// Directed bench for the 2x2 configuration: vector table for routing/contention,
// hand sequences for backpressure, wrap, head-of-line blocking and mid-run reset.

module tb_crossbar_nxn_rr_buffered;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic [1:0] in_dest, in_valid, in_ready;
  logic [7:0] out_data;
  logic [1:0] out_src, out_valid, out_ready;

  int checks = 0;
  int errors = 0;

  crossbar_nxn_rr_buffered #(.WIDTH(4), .DEST_W(1), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_dest   (in_dest),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] iv;
    logic [7:0] id;
    logic [1:0] idst;
    logic [1:0] ordy;
    logic [1:0] e_irdy;
    logic [1:0] e_ov;
    logic [7:0] e_od;
    logic [1:0] e_os;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [1:0] iv, input logic [7:0] id, input logic [1:0] idst,
                      input logic [1:0] ordy);
    in_valid  = iv;
    in_data   = id;
    in_dest   = idst;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] od(input int j);
    return out_data[j*4 +: 4];
  endfunction

  int   accepted, nxt, n;
  logic acc;
  logic [3:0] got[8];

  initial begin
    // cross routing (in0->out1, in1->out0), then contention on out0
    vecs[0]  = '{2'b11, 8'h53, 2'b01, 2'b11, 2'b11, 2'b00, 8'h00, 2'b00};
    vecs[1]  = '{2'b00, 8'h00, 2'b00, 2'b11, 2'b11, 2'b11, 8'h35, 2'b01};
    vecs[2]  = '{2'b00, 8'h00, 2'b00, 2'b11, 2'b11, 2'b00, 8'h00, 2'b00};
    vecs[3]  = '{2'b11, 8'h91, 2'b00, 2'b11, 2'b11, 2'b00, 8'h00, 2'b00};
    vecs[4]  = '{2'b11, 8'hA2, 2'b00, 2'b11, 2'b11, 2'b01, 8'h01, 2'b00};
    vecs[5]  = '{2'b11, 8'hB3, 2'b00, 2'b11, 2'b11, 2'b01, 8'h09, 2'b01};
    vecs[6]  = '{2'b00, 8'h00, 2'b00, 2'b11, 2'b11, 2'b01, 8'h02, 2'b00};
    vecs[7]  = '{2'b00, 8'h00, 2'b00, 2'b11, 2'b11, 2'b01, 8'h0A, 2'b01};
    vecs[8]  = '{2'b00, 8'h00, 2'b00, 2'b11, 2'b11, 2'b01, 8'h03, 2'b00};
    vecs[9]  = '{2'b00, 8'h00, 2'b00, 2'b11, 2'b11, 2'b01, 8'h0B, 2'b01};
    vecs[10] = '{2'b00, 8'h00, 2'b00, 2'b11, 2'b11, 2'b00, 8'h00, 2'b00};

    // reset with inputs offered
    rst_n = 1'b0; in_valid = 2'b11; in_data = 8'hFF; in_dest = 2'b00; out_ready = 2'b11;
    @(posedge clk); @(posedge clk); #1;
    chk("rst in_ready", in_ready, 2'b00);
    chk("rst out_valid", out_valid, 2'b00);
    chk("rst out_data", out_data, 8'h00);
    chk("rst out_src", out_src, 2'b00);
    in_valid = 2'b00;
    rst_n = 1'b1;
    #1;
    chk("release in_ready", in_ready, 2'b11);
    step(2'b00, 8'h00, 2'b00, 2'b11);
    chk("release out_valid", out_valid, 2'b00);

    for (int v = 0; v < 11; v++) begin
      step(vecs[v].iv, vecs[v].id, vecs[v].idst, vecs[v].ordy);
      chk($sformatf("vec%0d in_ready", v), in_ready, vecs[v].e_irdy);
      chk($sformatf("vec%0d out_valid", v), out_valid, vecs[v].e_ov);
      for (int j = 0; j < 2; j++)
        if (vecs[v].e_ov[j]) begin
          chk($sformatf("vec%0d out%0d data", v, j), od(j), vecs[v].e_od[j*4 +: 4]);
          chk($sformatf("vec%0d out%0d src", v, j), out_src[j], vecs[v].e_os[j]);
        end
    end

    // backpressure on out0: 1 in the output register plus 4 in the FIFO
    accepted = 0; nxt = 1;
    out_ready = 2'b10;
    for (int k = 0; k < 8; k++) begin
      in_valid = {1'b0, nxt <= 7};
      in_data  = {4'h0, 4'(nxt)};
      in_dest  = 2'b00;
      acc = in_valid[0] & in_ready[0];
      @(posedge clk); #1;
      if (acc) begin accepted++; nxt++; end
      if (k >= 1) begin
        chk($sformatf("bp hold valid k%0d", k), out_valid[0], 1'b1);
        chk($sformatf("bp hold data k%0d", k), od(0), 4'h1);
      end
    end
    chk("bp accepted", accepted, 5);
    chk("bp in_ready0", in_ready[0], 1'b0);

    // drain: 1..7 back-to-back, 6 and 7 pushed across the pointer wrap
    out_ready = 2'b11; n = 0;
    for (int k = 0; k < 7; k++) begin
      if (out_valid[0]) begin got[n] = od(0); n++; end
      in_valid = {1'b0, nxt <= 7};
      in_data  = {4'h0, 4'(nxt)};
      acc = in_valid[0] & in_ready[0];
      @(posedge clk); #1;
      if (acc) begin accepted++; nxt++; end
    end
    chk("drain beats", n, 7);
    for (int i = 0; i < n; i++) chk($sformatf("drain beat%0d", i), got[i], 4'(i + 1));
    chk("drain accepted", accepted, 7);
    step(2'b00, 8'h00, 2'b00, 2'b11);
    chk("drain idle", out_valid, 2'b00);

    // head-of-line: filler E from in1 occupies out0, in0 holds C(dest0) then D(dest1)
    step(2'b11, 8'hEC, 2'b00, 2'b10);
    chk("hol push valid", out_valid, 2'b00);
    step(2'b01, 8'h0D, 2'b01, 2'b10);
    chk("hol filler valid", out_valid, 2'b01);
    chk("hol filler data", od(0), 4'hE);
    chk("hol filler src", out_src[0], 1'b1);
    for (int k = 0; k < 4; k++) begin
      step(2'b00, 8'h00, 2'b00, 2'b10);
      chk($sformatf("hol blocked valid k%0d", k), out_valid, 2'b01);
      chk($sformatf("hol blocked data k%0d", k), od(0), 4'hE);
    end
    step(2'b00, 8'h00, 2'b00, 2'b11);
    chk("hol C valid", out_valid, 2'b01);
    chk("hol C data", od(0), 4'hC);
    chk("hol C src", out_src[0], 1'b0);
    step(2'b00, 8'h00, 2'b00, 2'b11);
    chk("hol D valid", out_valid, 2'b10);
    chk("hol D data", od(1), 4'hD);
    chk("hol D src", out_src[1], 1'b0);
    step(2'b00, 8'h00, 2'b00, 2'b11);
    chk("hol idle", out_valid, 2'b00);

    // mid-run reset with both outputs loaded and FIFOs non-empty
    step(2'b11, 8'h81, 2'b10, 2'b00);
    step(2'b11, 8'h92, 2'b10, 2'b00);
    step(2'b00, 8'h00, 2'b00, 2'b00);
    chk("pre-rst valid", out_valid, 2'b11);
    chk("pre-rst data", out_data, 8'h81);
    chk("pre-rst src", out_src, 2'b10);
    rst_n = 1'b0;
    #1;
    chk("async rst valid", out_valid, 2'b00);
    chk("async rst data", out_data, 8'h00);
    chk("async rst src", out_src, 2'b00);
    chk("async rst in_ready", in_ready, 2'b00);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(2'b00, 8'h00, 2'b00, 2'b11);
      chk($sformatf("post-rst valid k%0d", k), out_valid, 2'b00);
      chk($sformatf("post-rst in_ready k%0d", k), in_ready, 2'b11);
    end

    // after reset input 0 has first priority on every output
    step(2'b11, 8'h64, 2'b00, 2'b11);
    chk("prio push valid", out_valid, 2'b00);
    step(2'b00, 8'h00, 2'b00, 2'b11);
    chk("prio first valid", out_valid, 2'b01);
    chk("prio first data", od(0), 4'h4);
    chk("prio first src", out_src[0], 1'b0);
    step(2'b00, 8'h00, 2'b00, 2'b11);
    chk("prio second data", od(0), 4'h6);
    chk("prio second src", out_src[0], 1'b1);
    step(2'b00, 8'h00, 2'b00, 2'b11);
    chk("prio idle", out_valid, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
